// File: rtl/instr_register_pipe.sv
// Instruction register with embedded ALU: latches {opcode,a,b}, computes, stores {opcode,a,b,result,err}.
// Latency: simple/illegal ops visible one edge after accept; DIV/MOD/POW need OP_WIDTH more edges.
// Backpressure: wr_ready high only in IDLE; requester holds wr_valid until accepted.
module instr_register_pipe #(
  parameter int OP_WIDTH   = 32,
  parameter int RES_WIDTH  = 2*OP_WIDTH,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            opcode,
  input  logic [OP_WIDTH-1:0]   operand_a,
  input  logic [OP_WIDTH-1:0]   operand_b,
  input  logic [ADDR_WIDTH-1:0] write_pointer,
  input  logic [ADDR_WIDTH-1:0] read_pointer,
  output logic [3:0]            rd_opcode,
  output logic [OP_WIDTH-1:0]   rd_operand_a,
  output logic [OP_WIDTH-1:0]   rd_operand_b,
  output logic [RES_WIDTH-1:0]  rd_result,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] done_pointer
);

  localparam int CNT_W = $clog2(OP_WIDTH);

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;
  localparam logic [3:0] OP_POW   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                       state_q;
  logic [3:0]                   op_q;
  logic signed [OP_WIDTH-1:0]   a_q;
  logic signed [OP_WIDTH-1:0]   b_q;
  logic [ADDR_WIDTH-1:0]        wp_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         done_q;
  logic [ADDR_WIDTH-1:0]        done_ptr_q;

  // Divider works on magnitudes; remainder keeps one spare bit for the trial subtract.
  logic [OP_WIDTH:0]            div_rem_q, div_rem_d, div_shift;
  logic [OP_WIDTH-1:0]          div_quo_q, div_quo_d, div_dvs_q;

  // Square-and-multiply, exponent consumed LSB first.
  logic [RES_WIDTH-1:0]         pow_res_q, pow_res_d, pow_base_q, pow_base_d;
  logic [OP_WIDTH-1:0]          pow_exp_q, pow_exp_d;

  logic [3:0]                   mem_op_q  [DEPTH];
  logic [OP_WIDTH-1:0]          mem_a_q   [DEPTH];
  logic [OP_WIDTH-1:0]          mem_b_q   [DEPTH];
  logic [RES_WIDTH-1:0]         mem_res_q [DEPTH];
  logic [DEPTH-1:0]             mem_vld_q;
  logic [DEPTH-1:0]             mem_err_q;

  logic                         is_iter;
  logic [OP_WIDTH-1:0]          abs_a, abs_b;
  logic signed [RES_WIDTH-1:0]  a_ext, b_ext;
  logic [RES_WIDTH-1:0]         quo_mag, rem_mag;
  logic [RES_WIDTH-1:0]         wr_res;
  logic                         wr_err;

  assign is_iter  = (opcode == OP_DIV) || (opcode == OP_MOD) || (opcode == OP_POW);
  assign abs_a    = operand_a[OP_WIDTH-1] ? -operand_a : operand_a;
  assign abs_b    = operand_b[OP_WIDTH-1] ? -operand_b : operand_b;

  assign wr_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign done_pointer = done_ptr_q;

  // One restoring-division step: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    div_shift = {div_rem_q[OP_WIDTH-1:0], div_quo_q[OP_WIDTH-1]};
    div_rem_d = div_shift;
    div_quo_d = {div_quo_q[OP_WIDTH-2:0], 1'b0};
    if (div_shift >= {1'b0, div_dvs_q}) begin
      div_rem_d    = div_shift - {1'b0, div_dvs_q};
      div_quo_d[0] = 1'b1;
    end
  end

  // One square-and-multiply step, keeping only the low RES_WIDTH bits.
  always_comb begin
    pow_res_d  = pow_exp_q[0] ? pow_res_q * pow_base_q : pow_res_q;
    pow_base_d = pow_base_q * pow_base_q;
    pow_exp_d  = pow_exp_q >> 1;
  end

  // Final result/err selection for the entry written in WRITE.
  always_comb begin
    a_ext   = RES_WIDTH'(a_q);
    b_ext   = RES_WIDTH'(b_q);
    quo_mag = RES_WIDTH'(div_quo_q);
    rem_mag = RES_WIDTH'(div_rem_q);
    wr_res  = '0;
    wr_err  = 1'b0;
    case (op_q)
      OP_ZERO:  wr_res = '0;
      OP_PASSA: wr_res = a_ext;
      OP_PASSB: wr_res = b_ext;
      OP_ADD:   wr_res = a_ext + b_ext;
      OP_SUB:   wr_res = a_ext - b_ext;
      OP_MULT:  wr_res = a_ext * b_ext;
      OP_DIV: begin
        if (b_q == '0) wr_err = 1'b1;
        else           wr_res = (a_q[OP_WIDTH-1] ^ b_q[OP_WIDTH-1]) ? -quo_mag : quo_mag;
      end
      OP_MOD: begin
        if (b_q == '0) wr_err = 1'b1;
        else           wr_res = a_q[OP_WIDTH-1] ? -rem_mag : rem_mag;
      end
      OP_POW: begin
        if (b_q[OP_WIDTH-1]) wr_err = 1'b1;
        else if (a_q != '0)  wr_res = pow_res_q;
      end
      default:  wr_err = 1'b1;
    endcase
  end

  // Control FSM plus operand/iteration registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wp_q       <= '0;
      cnt_q      <= '0;
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_dvs_q  <= '0;
      pow_res_q  <= '0;
      pow_base_q <= '0;
      pow_exp_q  <= '0;
      done_q     <= 1'b0;
      done_ptr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wr_valid) begin
            op_q       <= opcode;
            a_q        <= operand_a;
            b_q        <= operand_b;
            wp_q       <= write_pointer;
            cnt_q      <= '0;
            div_rem_q  <= '0;
            div_quo_q  <= abs_a;
            div_dvs_q  <= abs_b;
            pow_res_q  <= RES_WIDTH'(1);
            pow_base_q <= RES_WIDTH'(signed'(operand_a));
            pow_exp_q  <= operand_b;
            state_q    <= is_iter ? S_EXEC : S_WRITE;
          end
        end
        S_EXEC: begin
          div_rem_q  <= div_rem_d;
          div_quo_q  <= div_quo_d;
          pow_res_q  <= pow_res_d;
          pow_base_q <= pow_base_d;
          pow_exp_q  <= pow_exp_d;
          cnt_q      <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(OP_WIDTH-1)) state_q <= S_WRITE;
        end
        S_WRITE: begin
          done_q     <= 1'b1;
          done_ptr_q <= wp_q;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Entry storage; out-of-range pointers drop the write but done still pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_op_q[i]  <= '0;
        mem_a_q[i]   <= '0;
        mem_b_q[i]   <= '0;
        mem_res_q[i] <= '0;
      end
      mem_vld_q <= '0;
      mem_err_q <= '0;
    end else if ((state_q == S_WRITE) && (int'(wp_q) < DEPTH)) begin
      mem_op_q[wp_q]  <= op_q;
      mem_a_q[wp_q]   <= a_q;
      mem_b_q[wp_q]   <= b_q;
      mem_res_q[wp_q] <= wr_res;
      mem_vld_q[wp_q] <= 1'b1;
      mem_err_q[wp_q] <= wr_err;
    end
  end

  // Combinational read port; out-of-range pointers read as an empty entry.
  always_comb begin
    rd_opcode    = '0;
    rd_operand_a = '0;
    rd_operand_b = '0;
    rd_result    = '0;
    rd_valid     = 1'b0;
    rd_err       = 1'b0;
    if (int'(read_pointer) < DEPTH) begin
      rd_opcode    = mem_op_q[read_pointer];
      rd_operand_a = mem_a_q[read_pointer];
      rd_operand_b = mem_b_q[read_pointer];
      rd_result    = mem_res_q[read_pointer];
      rd_valid     = mem_vld_q[read_pointer];
      rd_err       = mem_err_q[read_pointer];
    end
  end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Bench for instr_register_pipe: directed and random ops against an arithmetic reference model.
// Latency: measures accept-to-done and accept-to-accept cycle counts.
// Backpressure: holds wr_valid through busy periods and checks it is ignored until IDLE.
module tb_instr_register_pipe;

  localparam int W  = 32;
  localparam int RW = 64;
  localparam int D  = 32;
  localparam int AW = 5;

  typedef logic [133:0] word_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [AW-1:0] write_pointer;
  logic [AW-1:0] read_pointer;
  logic [3:0]    rd_opcode;
  logic [W-1:0]  rd_operand_a;
  logic [W-1:0]  rd_operand_b;
  logic [RW-1:0] rd_result;
  logic          rd_valid;
  logic          rd_err;
  logic          busy;
  logic          done;
  logic [AW-1:0] done_pointer;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_register_pipe #(.OP_WIDTH(W), .RES_WIDTH(RW), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .rd_opcode(rd_opcode), .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
    .rd_result(rd_result), .rd_valid(rd_valid), .rd_err(rd_err),
    .busy(busy), .done(done), .done_pointer(done_pointer)
  );

  word_t rd_word;
  assign rd_word = {rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_valid, rd_err};

  // Reference model of the entry array
  logic [3:0]    m_op  [D];
  logic [W-1:0]  m_a   [D];
  logic [W-1:0]  m_b   [D];
  logic [RW-1:0] m_res [D];
  logic          m_vld [D];
  logic          m_err [D];

  // Directed cases with hand-derived results
  logic [3:0]    dir_op  [9] = '{4'd3, 4'd6, 4'd7, 4'd6, 4'd12, 4'd8, 4'd8, 4'd8, 4'd5};
  logic [W-1:0]  dir_a   [9] = '{32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd9, 32'd1, 32'd3, 32'd0, 32'd2, 32'h7FFF_FFFF};
  logic [W-1:0]  dir_b   [9] = '{32'hFFFF_FFFD, 32'd2, 32'd2, 32'd0, 32'd1, 32'd4, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  int            dir_ptr [9] = '{3, 4, 4, 5, 6, 7, 8, 9, 10};
  logic [RW-1:0] dir_res [9] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                                 64'd81, 64'd0, 64'd0, 64'h3FFF_FFFF_0000_0001};
  logic          dir_err [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  int            dir_lat [9] = '{2, 34, 34, 34, 2, 34, 34, 34, 2};

  function automatic void ref_compute(input logic [3:0] op, input logic signed [W-1:0] a,
                                      input logic signed [W-1:0] b,
                                      output logic [RW-1:0] res, output logic err);
    longint la = a;
    longint lb = b;
    logic [RW-1:0] p;
    res = '0;
    err = 1'b0;
    case (op)
      4'd0: res = '0;
      4'd1: res = la;
      4'd2: res = lb;
      4'd3: res = la + lb;
      4'd4: res = la - lb;
      4'd5: res = la * lb;
      4'd6: if (b == 0) err = 1'b1; else res = la / lb;
      4'd7: if (b == 0) err = 1'b1; else res = la % lb;
      4'd8: begin
        if (b < 0) err = 1'b1;
        else if (a != 0) begin
          p = 64'd1;
          for (int i = 0; i < lb; i++) p = p * la;
          res = p;
        end
      end
      default: err = 1'b1;
    endcase
  endfunction

  function automatic word_t model_word(input int p);
    return {m_op[p], m_a[p], m_b[p], m_res[p], m_vld[p], m_err[p]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_vld[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_write(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int p);
    logic [RW-1:0] r;
    logic e;
    ref_compute(op, a, b, r, e);
    m_op[p] = op; m_a[p] = a; m_b[p] = b; m_res[p] = r; m_vld[p] = 1'b1; m_err[p] = e;
  endtask

  task automatic read_entry(input int p);
    read_pointer = AW'(p);
    #1;
  endtask

  // Drives one request, returns accept cycle, accept-to-done latency and the entry seen before the write.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int p, output int lat, output int acc_cyc, output word_t pre);
    int g;
    wr_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = AW'(p);
    g = 0;
    while (wr_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc  = cyc;
    wr_valid = 1'b0;
    read_entry(p);
    pre = rd_word;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    read_entry(p);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_valid = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
    write_pointer = '0; read_pointer = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if ({wr_ready, busy, done, done_pointer} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL reset_status: got rdy/busy/done/ptr %b%b%b/%0d required 100/0",
               wr_ready, busy, done, done_pointer);
    end
    for (int i = 0; i < D; i++) begin
      read_entry(i);
      checks++;
      if (rd_word !== 134'd0) begin
        errors++;
        $display("FAIL reset_entry[%0d]: got %h required 0", i, rd_word);
      end
    end
  endtask

  task automatic test_directed();
    int lat, acc;
    word_t pre, old;
    for (int i = 0; i < 9; i++) begin
      old = model_word(dir_ptr[i]);
      do_op(dir_op[i], dir_a[i], dir_b[i], dir_ptr[i], lat, acc, pre);
      model_write(dir_op[i], dir_a[i], dir_b[i], dir_ptr[i]);
      checks++;
      if (lat !== dir_lat[i]) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, dir_lat[i]);
      end
      checks++;
      if (pre !== old) begin
        errors++;
        $display("FAIL dir%0d_prewrite: got %h required %h", i, pre, old);
      end
      checks++;
      if ({rd_result, rd_valid, rd_err} !== {dir_res[i], 1'b1, dir_err[i]}) begin
        errors++;
        $display("FAIL dir%0d_result: got %h v%b e%b required %h v1 e%b", i, rd_result, rd_valid,
                 rd_err, dir_res[i], dir_err[i]);
      end
      checks++;
      if (rd_word !== model_word(dir_ptr[i])) begin
        errors++;
        $display("FAIL dir%0d_entry: got %h required %h", i, rd_word, model_word(dir_ptr[i]));
      end
      checks++;
      if (done_pointer !== AW'(dir_ptr[i])) begin
        errors++;
        $display("FAIL dir%0d_done_ptr: got %0d required %0d", i, done_pointer, dir_ptr[i]);
      end
      @(negedge clk);
      checks++;
      if ({done, done_pointer} !== {1'b0, AW'(dir_ptr[i])}) begin
        errors++;
        $display("FAIL dir%0d_done_pulse: got done %b ptr %0d required 0 ptr %0d", i, done,
                 done_pointer, dir_ptr[i]);
      end
    end
  endtask

  task automatic test_random_simple();
    int lat, acc, p, r;
    word_t pre, old;
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int n = 0; n < 30; n++) begin
      r  = $urandom_range(0, 12);
      op = (r <= 5) ? 4'(r) : 4'(r + 3);
      a  = $urandom; b = $urandom; p = $urandom_range(0, D-1);
      old = model_word(p);
      do_op(op, a, b, p, lat, acc, pre);
      model_write(op, a, b, p);
      checks++;
      if (lat !== 2 || pre !== old) begin
        errors++;
        $display("FAIL rs%0d_timing: got lat %0d pre %h required lat 2 pre %h", n, lat, pre, old);
      end
      checks++;
      if (rd_word !== model_word(p)) begin
        errors++;
        $display("FAIL rs%0d_entry op%0d: got %h required %h", n, op, rd_word, model_word(p));
      end
    end
    for (int i = 0; i < D; i++) begin
      read_entry(i);
      checks++;
      if (rd_word !== model_word(i)) begin
        errors++;
        $display("FAIL rs_sweep[%0d]: got %h required %h", i, rd_word, model_word(i));
      end
    end
  endtask

  task automatic test_random_iter();
    int lat, acc, p;
    word_t pre;
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int n = 0; n < 12; n++) begin
      op = 4'($urandom_range(6, 8));
      a  = $urandom; b = $urandom; p = $urandom_range(0, D-1);
      if (op == 4'd8) begin
        b = $urandom_range(0, 40);
        if ($urandom_range(0, 4) == 0) b = b | 32'h8000_0000;
        if ($urandom_range(0, 5) == 0) a = '0;
      end else begin
        if ($urandom_range(0, 3) == 0) b = '0;
        if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
        if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 1000)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      end
      do_op(op, a, b, p, lat, acc, pre);
      model_write(op, a, b, p);
      checks++;
      if (lat !== W + 2) begin
        errors++;
        $display("FAIL ri%0d_latency: got %0d required %0d", n, lat, W + 2);
      end
      checks++;
      if (rd_word !== model_word(p)) begin
        errors++;
        $display("FAIL ri%0d_entry op%0d: got %h required %h", n, op, rd_word, model_word(p));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, acc0, acc1;
    word_t pre;
    do_op(4'd3, 32'd10, 32'd20, 20, lat, acc0, pre);
    model_write(4'd3, 32'd10, 32'd20, 20);
    for (int n = 0; n < 3; n++) begin
      do_op(4'd4, 32'(n), 32'd7, 21 + n, lat, acc1, pre);
      model_write(4'd4, 32'(n), 32'd7, 21 + n);
      checks++;
      if (acc1 - acc0 !== 2) begin
        errors++;
        $display("FAIL b2b_simple%0d: got spacing %0d required 2", n, acc1 - acc0);
      end
      acc0 = acc1;
    end
    do_op(4'd6, 32'd1000, 32'd3, 25, lat, acc0, pre);
    model_write(4'd6, 32'd1000, 32'd3, 25);
    do_op(4'd7, 32'd1000, 32'd3, 26, lat, acc1, pre);
    model_write(4'd7, 32'd1000, 32'd3, 26);
    checks++;
    if (acc1 - acc0 !== W + 2) begin
      errors++;
      $display("FAIL b2b_iter: got spacing %0d required %0d", acc1 - acc0, W + 2);
    end
    checks++;
    if (rd_word !== model_word(26)) begin
      errors++;
      $display("FAIL b2b_entry: got %h required %h", rd_word, model_word(26));
    end
  endtask

  task automatic test_hold_exec();
    int lat;
    wr_valid = 1'b1; opcode = 4'd6; operand_a = 32'hFFFF_FF9C; operand_b = 32'd7; write_pointer = 5'd12;
    @(posedge clk);
    @(negedge clk);
    opcode = 4'd3; operand_a = 32'd1; operand_b = 32'd2; write_pointer = 5'd13;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    model_write(4'd6, 32'hFFFF_FF9C, 32'd7, 12);
    checks++;
    if (lat !== W + 2) begin
      errors++;
      $display("FAIL hold_latency: got %0d required %0d", lat, W + 2);
    end
    read_entry(12);
    checks++;
    if (rd_word !== model_word(12)) begin
      errors++;
      $display("FAIL hold_entry12: got %h required %h", rd_word, model_word(12));
    end
    read_entry(13);
    checks++;
    if (rd_word !== model_word(13)) begin
      errors++;
      $display("FAIL hold_entry13_early: got %h required %h", rd_word, model_word(13));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_accept: got busy %b required 1", busy);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    model_write(4'd3, 32'd1, 32'd2, 13);
    read_entry(13);
    checks++;
    if ({done, done_pointer, rd_word} !== {1'b1, 5'd13, model_word(13)}) begin
      errors++;
      $display("FAIL hold_entry13: got done %b ptr %0d %h required 1 13 %h", done, done_pointer,
               rd_word, model_word(13));
    end
  endtask

  task automatic test_reset_mid_exec();
    int n;
    wr_valid = 1'b1; opcode = 4'd7; operand_a = 32'd12345; operand_b = 32'd11; write_pointer = 5'd14;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy_before: got %b required 1", busy);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    checks++;
    if ({busy, wr_ready, done, done_pointer} !== {1'b0, 1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL midreset_status: got busy/rdy/done/ptr %b%b%b/%0d required 010/0",
               busy, wr_ready, done, done_pointer);
    end
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL midreset_done: got %0d pulses required 0", n);
    end
    for (int i = 0; i < D; i++) begin
      read_entry(i);
      checks++;
      if (rd_word !== model_word(i)) begin
        errors++;
        $display("FAIL midreset_entry[%0d]: got %h required %h", i, rd_word, model_word(i));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random_simple();
    test_random_iter();
    test_back_to_back();
    test_hold_exec();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
